ws2812_serializer: RTL and testbench

// - Downstream stage of the WS2812 register block. Walks the GRB pixel RAM
//   (3 bytes/pixel, byte 0 = G of pixel 0) in address order.
// - Serialises each byte MSB-first onto the single-wire WS2812 data line

---
 rtl/ws2812_serializer.sv | 181 ++++++++++++++++++
 tb/tb_ws2812_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_serializer.sv
// WS2812 serializer: streams GRB bytes from the pixel RAM as NRZ pulses.
// Define WS2812_TRIGGER_EN to start frames on update_req instead of free-running.
module ws2812_serializer #(
    parameter int MAX_PIXELS     = 4,
    parameter int T_BIT_CYCLES   = 34,
    parameter int T0H_CYCLES     = 10,
    parameter int T1H_CYCLES     = 19,
    parameter int T_LATCH_CYCLES = 2160
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] number_of_pixels,
    output logic [9:0] pixel_addr,
    input  logic [7:0] pixel_dbi,
    output logic       ws2812_data,
    output logic       busy,
    output logic       frame_done
`ifdef WS2812_TRIGGER_EN
    ,
    input  logic       update_req
`endif
);

    localparam int CNT_MAX = (T_LATCH_CYCLES > T_BIT_CYCLES) ?
                             T_LATCH_CYCLES : T_BIT_CYCLES;
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] PF_LAST    = CW'(1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(T_BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(T_LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [9:0]    byte_idx;
    logic [9:0]    total;
    logic [7:0]    shift_q;
    logic [7:0]    next_q;

    logic          frame_due;
    logic          last_byte;
    logic [CW-1:0] th_last;
    logic [7:0]    n_clamp;
    logic [9:0]    frame_total;

`ifdef WS2812_TRIGGER_EN
    logic pending;

    // Requests during a frame collapse into a single follow-up frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (state == S_IDLE) begin
            pending <= 1'b0;
        end else if (update_req) begin
            pending <= 1'b1;
        end
    end

    assign frame_due = update_req | pending;
`else
    assign frame_due = 1'b1;
`endif

    always_comb begin
        n_clamp = (number_of_pixels > 8'(MAX_PIXELS)) ?
                  8'(MAX_PIXELS) : number_of_pixels;
        frame_total = 10'(n_clamp) * 10'd3;
        last_byte = (byte_idx + 10'd1) >= total;
        th_last = shift_q[7] ? T1H_LAST : T0H_LAST;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (frame_due) state_nxt = S_PREFETCH;
            end
            S_PREFETCH: begin
                if (cnt == PF_LAST)
                    state_nxt = (total == 10'd0) ? S_LATCH : S_HIGH;
            end
            S_HIGH: begin
                if (cnt == th_last) state_nxt = S_LOW;
            end
            S_LOW: begin
                if (cnt == BIT_LAST)
                    state_nxt = (bit_idx == 3'd0 && last_byte) ?
                                S_LATCH : S_HIGH;
            end
            S_LATCH: begin
                if (cnt == LATCH_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ws2812_data = (state == S_HIGH);
        busy        = (state != S_IDLE);
        frame_done  = (state == S_LATCH) && (cnt == LATCH_LAST);
    end

    // cnt runs across HIGH and LOW so each bit spans exactly T_BIT_CYCLES
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 10'd0;
            total      <= 10'd0;
            shift_q    <= 8'd0;
            next_q     <= 8'd0;
            pixel_addr <= 10'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (frame_due) begin
                        total      <= frame_total;
                        pixel_addr <= 10'd0;
                    end
                end
                S_PREFETCH: begin
                    if (cnt == PF_LAST) begin
                        cnt      <= '0;
                        shift_q  <= pixel_dbi;
                        bit_idx  <= 3'd7;
                        byte_idx <= 10'd0;
                        if (total > 10'd1) pixel_addr <= 10'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_HIGH, S_LOW: begin
                    if (bit_idx == 3'd7 && cnt == CNT_ONE)
                        next_q <= pixel_dbi;
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx != 3'd0) begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            bit_idx <= bit_idx - 3'd1;
                        end else if (!last_byte) begin
                            shift_q  <= next_q;
                            bit_idx  <= 3'd7;
                            byte_idx <= byte_idx + 10'd1;
                            if ((byte_idx + 10'd2) < total)
                                pixel_addr <= byte_idx + 10'd2;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_LATCH: begin
                    cnt <= (cnt == LATCH_LAST) ? '0 : cnt + CNT_ONE;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: bit timing, addressing, latch, reset.
// Builds for both the free-running and WS2812_TRIGGER_EN configurations.
module tb_ws2812_serializer;

    localparam int MAXP  = 4;
    localparam int TBIT  = 34;
    localparam int T0H   = 10;
    localparam int T1H   = 19;
    localparam int TLAT  = 2160;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] number_of_pixels;
    logic [9:0] pixel_addr;
    logic [7:0] pixel_dbi = 8'd0;
    logic       ws2812_data;
    logic       busy;
    logic       frame_done;
`ifdef WS2812_TRIGGER_EN
    logic       update_req = 1'b0;
`endif

    logic [7:0] mem [0:1023];

    int n_cmp = 0;
    int n_mis = 0;

    ws2812_serializer #(
        .MAX_PIXELS(MAXP),
        .T_BIT_CYCLES(TBIT),
        .T0H_CYCLES(T0H),
        .T1H_CYCLES(T1H),
        .T_LATCH_CYCLES(TLAT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .number_of_pixels(number_of_pixels),
        .pixel_addr(pixel_addr),
        .pixel_dbi(pixel_dbi),
        .ws2812_data(ws2812_data),
        .busy(busy),
        .frame_done(frame_done)
`ifdef WS2812_TRIGGER_EN
        ,
        .update_req(update_req)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid one clock after the address
    always @(posedge clk) pixel_dbi <= mem[pixel_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic kick();
`ifdef WS2812_TRIGGER_EN
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
`endif
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (busy !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("frame_start", 32'(busy), 32'd1);
    endtask

    task automatic check_frame(input int n_req, input int n_next,
                               input bit req_twice);
        int n, total, hi_lead, hi_tot, exp_h, max_addr, bad, fd;
        bit lead;
        logic [7:0] b;
        n = (n_req > MAXP) ? MAXP : n_req;
        total = n * 3;
        bad = 0;
        fd = 0;
        max_addr = 0;
        wait_start();
        number_of_pixels = 8'(n_next);
        chk("prefetch_addr", 32'(pixel_addr), 32'd0);
        @(negedge clk);
        if (busy !== 1'b1 || ws2812_data !== 1'b0) bad++;
        for (int k = 0; k < total; k++) begin
            b = mem[k];
            for (int i = 7; i >= 0; i--) begin
                exp_h = b[i] ? T1H : T0H;
                lead = 1'b1;
                hi_lead = 0;
                hi_tot = 0;
                for (int c = 0; c < TBIT; c++) begin
                    @(negedge clk);
`ifdef WS2812_TRIGGER_EN
                    update_req = req_twice && k == 0 &&
                                 (i == 6 || i == 4) && c == 5;
`endif
                    if (c == 0 && i == 7)
                        chk($sformatf("addr_byte%0d", k), 32'(pixel_addr),
                            32'((k + 1 < total) ? k + 1 : k));
                    if (ws2812_data === 1'b1) begin
                        hi_tot++;
                        if (lead) hi_lead++;
                    end else begin
                        lead = 1'b0;
                    end
                    if (busy !== 1'b1) bad++;
                    if (frame_done !== 1'b0) fd++;
                    if (int'(pixel_addr) > max_addr) max_addr = int'(pixel_addr);
                end
                chk($sformatf("lead_high_b%0d_i%0d", k, i), 32'(hi_lead), 32'(exp_h));
                chk($sformatf("tot_high_b%0d_i%0d", k, i), 32'(hi_tot), 32'(exp_h));
            end
        end
        for (int i = 0; i < TLAT; i++) begin
            @(negedge clk);
            if (ws2812_data !== 1'b0 || busy !== 1'b1) bad++;
            if (i == TLAT - 1) chk("frame_done_last", 32'(frame_done), 32'd1);
            else if (frame_done !== 1'b0) fd++;
            if (int'(pixel_addr) > max_addr) max_addr = int'(pixel_addr);
        end
        chk("frame_done_extra", 32'(fd), 32'd0);
        chk("busy_data_bad", 32'(bad), 32'd0);
        if (total > 0) chk("addr_max", 32'(max_addr), 32'(total - 1));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_data", 32'(ws2812_data), 32'd0);
    endtask

    initial begin
        int hits;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'hFF; mem[1]  = 8'h00; mem[2]  = 8'hA5;
        mem[3] = 8'h12; mem[4]  = 8'h34; mem[5]  = 8'h56;
        mem[6] = 8'h80; mem[7]  = 8'h01; mem[8]  = 8'h7E;
        mem[9] = 8'hC3; mem[10] = 8'h5A; mem[11] = 8'h0F;

        reset_n = 1'b0;
        number_of_pixels = 8'd1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(ws2812_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(pixel_addr), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;

`ifdef WS2812_TRIGGER_EN
        hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0 || ws2812_data !== 1'b0) hits++;
        end
        chk("no_req_idle", 32'(hits), 32'd0);
`endif

        kick();
        check_frame(1, 2, 1'b0);
        kick();
        check_frame(2, 0, 1'b0);
        kick();
        check_frame(0, 200, 1'b0);
        // byte 11 is not fetched yet when the frame starts
        mem[11] = 8'h3C;
        kick();
        check_frame(200, 1, 1'b0);

        kick();
        wait_start();
        repeat (342) @(negedge clk);
        chk("abort_pre_data", 32'(ws2812_data), 32'd1);
        chk("abort_pre_addr", 32'(pixel_addr), 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_data", 32'(ws2812_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(pixel_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        kick();
        check_frame(1, 1, 1'b0);

`ifdef WS2812_TRIGGER_EN
        kick();
        check_frame(1, 1, 1'b1);
        check_frame(1, 1, 1'b0);
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || ws2812_data !== 1'b0) hits++;
        end
        chk("single_extra_frame", 32'(hits), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
